sha256_multiblock: RTL and testbench
====================================

SHA256_MULTIBLOCK -- requirements
Module: sha256_multiblock

Interface
REQ-001 Parameter NUM_OF_WORDS, default 20: message length in 32-bit words; legal range 1..4095; any other value SHALL fail elaboration.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request to hash; sampled only in IDLE.
REQ-005 message_addr  in  16  word address of message word 0.
REQ-006 output_addr  in  16  word address for digest word H0.
REQ-007 done  out  1  high exactly while in IDLE.
REQ-008 mem_clk  out  1  equals clk.
REQ-009 mem_we  out  1  memory write enable.
REQ-010 mem_addr  out  16  memory word address.
REQ-011 mem_write_data  out  32  memory write data.
REQ-012 mem_read_data  in  32  memory read data; valid one cycle after its address is presented.

Function
REQ-013 States SHALL be IDLE, LOAD, COMPUTE, UPDATE, WRITE.
REQ-014 Block count SHALL be nb = floor((NUM_OF_WORDS+2)/16)+1, computed at elaboration.
REQ-015 Padding: word index NUM_OF_WORDS = 32'h80000000; last two words of block nb-1 = 64-bit bit length NUM_OF_WORDS*32, upper word 0; all other words beyond the message = 0.
REQ-016 Padding words SHALL be generated internally; no memory read is issued for them.
REQ-017 IDLE with start=1 SHALL load H0..H7 with the FIPS 180-4 initial values, set block index 0, and enter LOAD; start=1 outside IDLE SHALL be ignored.
REQ-018 LOAD SHALL last exactly 17 cycles: cycle k (0..15) presents message_addr+16*b+k when that word is message data; cycle k+1 captures it into w[k]; a..h SHALL be loaded from H0..H7.
REQ-019 COMPUTE SHALL last exactly 64 cycles, one round per cycle, round t using K[t] and a 16-entry shifting schedule window.
REQ-020 UPDATE SHALL last 1 cycle: Hi <= Hi + corresponding working variable, mod 2^32; then LOAD for the next block, or WRITE after block nb-1.
REQ-021 WRITE SHALL last exactly 8 cycles with mem_we=1, mem_addr=output_addr+i, mem_write_data=Hi for i=0..7, then IDLE.
REQ-022 If start is sampled in cycle T, done SHALL rise at cycle T+1+82*nb+8.
REQ-023 mem_we SHALL be 0 in all states other than WRITE; mem_addr/mem_write_data are don't-care when not reading or writing.
REQ-024 All address arithmetic SHALL wrap modulo 2^16.
REQ-025 Digest registers SHALL hold their final value in IDLE until the next accepted start.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, done=1, mem_we=0, block index 0, round counter 0.
REQ-027 Reset asserted mid-operation SHALL abort without further memory writes; the next start after release SHALL hash from scratch.
REQ-028 Hash, working and schedule registers need no reset value.

Configuration
REQ-029 Macro SHA256_BSWAP_EN defined: each message word SHALL be byte-reversed on capture and each digest word byte-reversed on write.
REQ-030 SHA256_BSWAP_EN undefined: words SHALL be used and written unmodified; timing is identical in both builds.

Verification
REQ-031 NUM_OF_WORDS=1, word 32'h61626364, macro off -> nb=1; digest 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589 at output_addr..+7; done at T+91.
REQ-032 NUM_OF_WORDS=20, random message -> nb=2; digest matches software SHA-256 of the 80-byte message; done at T+173.
REQ-033 NUM_OF_WORDS=13 -> nb=1, length in words 14/15; NUM_OF_WORDS=14 -> nb=2, second block all zero except length 448; both match golden model.
REQ-034 reset_n pulsed low during COMPUTE of block 0 -> done=1 and mem_we=0 at once, no writes observed; subsequent start yields correct digest.
REQ-035 start held high through entire operation -> exactly one hash and 8 writes, then a new operation begins from IDLE; no restart mid-operation.
REQ-036 Macro on, message bytes stored little-endian per word -> digest equals REQ-031 value byte-reversed per word.

Source files
------------

// File: rtl/sha256_multiblock.sv
// SHA-256 over NUM_OF_WORDS 32-bit words read from a word-addressed memory; digest written back as 8 words.
// Latency: start sampled at T -> done at T+1+82*nb+8; no backpressure, memory answers one cycle after the address.
// Optional build macro SHA256_BSWAP_EN: byte-reverse message words on capture and digest words on write.
module sha256_multiblock #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    localparam int NB = (NUM_OF_WORDS + 2) / 16 + 1;
    localparam logic [31:0] NW     = 32'(NUM_OF_WORDS);
    localparam logic [31:0] LAST   = 32'(16 * NB - 1);
    localparam logic [31:0] BITLEN = 32'(NUM_OF_WORDS * 32);
    localparam logic [15:0] LASTB  = 16'(NB - 1);

    if (NUM_OF_WORDS < 1 || NUM_OF_WORDS > 4095) begin : g_bad_len
        $error("NUM_OF_WORDS must be in 1..4095");
    end

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] H_INIT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, UPDATE, WRITE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

`ifdef SHA256_BSWAP_EN
    function automatic logic [31:0] order(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction
`else
    function automatic logic [31:0] order(input logic [31:0] x);
        return x;
    endfunction
`endif

    function automatic logic [31:0] pad_word(input logic [31:0] idx);
        if (idx == NW)        return 32'h80000000;
        else if (idx == LAST) return BITLEN;
        else                  return 32'h0;
    endfunction

    state_t      state;
    logic [15:0] blk;
    logic [6:0]  cnt;
    logic [31:0] hv [8];
    logic [31:0] wk [8];
    logic [31:0] w  [16];

    logic [31:0] cur_idx, cap_idx, t1, t2, w_new;
    logic [3:0]  widx;

    // cur_idx: word addressed this LOAD cycle; cap_idx: word whose data arrives now
    assign cur_idx = {12'b0, blk, 4'b0} + 32'(cnt);
    assign cap_idx = cur_idx - 32'd1;
    assign widx    = 4'(cnt - 7'd1);

    assign t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
              + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[cnt[5:0]] + w[0];
    assign t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
              + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
    assign w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
                 + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            blk   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    blk   <= '0;
                    cnt   <= '0;
                    state <= LOAD;
                end
                LOAD: if (cnt == 7'd16) begin
                    cnt   <= '0;
                    state <= COMPUTE;
                end else begin
                    cnt <= cnt + 7'd1;
                end
                COMPUTE: if (cnt == 7'd63) begin
                    cnt   <= '0;
                    state <= UPDATE;
                end else begin
                    cnt <= cnt + 7'd1;
                end
                UPDATE: begin
                    cnt <= '0;
                    if (blk == LASTB) begin
                        state <= WRITE;
                    end else begin
                        blk   <= blk + 16'd1;
                        state <= LOAD;
                    end
                end
                WRITE: if (cnt == 7'd7) begin
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 7'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start) begin
                for (int i = 0; i < 8; i++) hv[i] <= H_INIT[i];
            end
            LOAD: if (cnt == 7'd0) begin
                for (int i = 0; i < 8; i++) wk[i] <= hv[i];
            end else begin
                w[widx] <= (cap_idx < NW) ? order(mem_read_data) : pad_word(cap_idx);
            end
            COMPUTE: begin
                for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                w[15] <= w_new;
                for (int i = 1; i < 8; i++) wk[i] <= wk[i - 1];
                wk[4] <= wk[3] + t1;
                wk[0] <= t1 + t2;
            end
            UPDATE: begin
                for (int i = 0; i < 8; i++) hv[i] <= hv[i] + wk[i];
            end
            default: ;
        endcase
    end

    assign done           = (state == IDLE);
    assign mem_clk        = clk;
    assign mem_we         = (state == WRITE);
    assign mem_write_data = order(hv[cnt[2:0]]);

    always_comb begin
        mem_addr = 16'h0;
        if (state == WRITE)
            mem_addr = output_addr + 16'(cnt[2:0]);
        else if (state == LOAD && cnt < 7'd16 && cur_idx < NW)
            mem_addr = message_addr + 16'({blk, 4'b0}) + 16'(cnt[3:0]);
    end
endmodule

// File: tb/tb_sha256_multiblock.sv
// Four instances (NUM_OF_WORDS 1, 20, 13, 14) share one memory image; expected digest writes are queued
// per instance at start and consumed by an independent monitor watching mem_we.
module tb_sha256_multiblock;
    localparam int NI = 4;
    localparam int NW [NI] = '{1, 20, 13, 14};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] ABCD_DIGEST =
        256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589;

    logic clk = 1'b0;
    logic reset_n;
    logic [NI-1:0]       start, done, mem_clk, mem_we;
    logic [NI-1:0][15:0] maddr, oaddr, mem_addr;
    logic [NI-1:0][31:0] wdata, rdata;
    logic [31:0]         mem [0:65535];
    logic [47:0]         exp_q [NI][$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha256_multiblock #(.NUM_OF_WORDS(NW[g])) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start[g]),
            .message_addr(maddr[g]), .output_addr(oaddr[g]),
            .done(done[g]), .mem_clk(mem_clk[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_write_data(wdata[g]),
            .mem_read_data(rdata[g])
        );
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) rdata[i] <= mem[mem_addr[i]];
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

`ifdef SHA256_BSWAP_EN
    function automatic logic [31:0] order(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction
`else
    function automatic logic [31:0] order(input logic [31:0] x);
        return x;
    endfunction
`endif

    // Textbook SHA-256: pad the whole message, expand 64 schedule words per block.
    function automatic logic [255:0] sha_ref(input int n, input logic [15:0] ma);
        logic [31:0] msg [$];
        logic [31:0] w [64];
        logic [31:0] hs [8];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [255:0] r;
        hs = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int j = 0; j < n; j++) msg.push_back(order(mem[16'(32'(ma) + j)]));
        msg.push_back(32'h80000000);
        while (msg.size() % 16 != 14) msg.push_back(32'h0);
        msg.push_back(32'h0);
        msg.push_back(32'(n * 32));
        for (int bi = 0; bi < msg.size() / 16; bi++) begin
            for (int t = 0; t < 16; t++) w[t] = msg[16 * bi + t];
            for (int t = 16; t < 64; t++)
                w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            {a, b, c, d, e, f, g, h} = {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
            for (int t = 0; t < 64; t++) begin
                t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                {h, g, f, e, d, c, b, a} = {g, f, e, d + t1, c, b, a, t1 + t2};
            end
            hs[0] += a; hs[1] += b; hs[2] += c; hs[3] += d;
            hs[4] += e; hs[5] += f; hs[6] += g; hs[7] += h;
        end
        for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = hs[i];
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fill(input int n, input logic [15:0] ma);
        for (int j = 0; j < n; j++) mem[16'(32'(ma) + j)] = $urandom();
    endtask

    // pre=1: start is already high from a held previous operation.
    task automatic run(input int i, input logic [15:0] ma, input logic [15:0] oa,
                       input bit hold, input bit pre, input bit kat);
        logic [255:0] dg;
        int n, nb;
        maddr[i] = ma;
        oaddr[i] = oa;
        if (!pre) begin
            @(negedge clk);
            start[i] = 1'b1;
        end
        dg = kat ? ABCD_DIGEST : sha_ref(NW[i], ma);
        for (int k = 0; k < 8; k++)
            exp_q[i].push_back({16'(32'(oa) + k), order(dg[255 - 32 * k -: 32])});
        @(posedge clk);
        #1 start[i] = hold;
        n = 1;
        while (n < 2000) begin
            @(negedge clk);
            if (done[i]) break;
            @(posedge clk);
            n++;
        end
        nb = (NW[i] + 2) / 16 + 1;
        check($sformatf("done_latency_dut%0d", i), 64'(n), 64'(1 + 82 * nb + 8));
    endtask

    initial begin : monitor
        logic [47:0] e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (mem_we[i] === 1'b1) begin
                    check($sformatf("write_expected_dut%0d", i), 64'(exp_q[i].size() != 0), 64'd1);
                    if (exp_q[i].size() != 0) begin
                        e = exp_q[i].pop_front();
                        check($sformatf("write_dut%0d", i), 64'({mem_addr[i], wdata[i]}), 64'(e));
                    end
                end
            end
        end
    end

    initial begin : stim
        start   = '0;
        maddr   = '0;
        oaddr   = '0;
        reset_n = 1'b0;
        #12;
        check("reset_done", 64'(done), 64'({NI{1'b1}}));
        check("reset_mem_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        mem[16'h0100] = order(32'h61626364);
        run(0, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1);
        fill(1, 16'h0300);
        run(0, 16'h0300, 16'h0400, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            fill(20, 16'h1000);
            run(1, 16'h1000, 16'h2000, 1'b0, 1'b0, 1'b0);
        end
        fill(20, 16'hFFF8);
        run(1, 16'hFFF8, 16'hFFFC, 1'b0, 1'b0, 1'b0);
        fill(13, 16'h3000);
        run(2, 16'h3000, 16'h3100, 1'b0, 1'b0, 1'b0);
        fill(14, 16'h4000);
        run(3, 16'h4000, 16'h4100, 1'b0, 1'b0, 1'b0);

        // abort during block-0 compute: no writes may follow
        fill(20, 16'h5000);
        maddr[1] = 16'h5000;
        oaddr[1] = 16'h5100;
        @(negedge clk);
        start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        repeat (40) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_done", 64'(done[1]), 64'd1);
        check("abort_mem_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(posedge clk);
        check("abort_idle", 64'(done[1]), 64'd1);
        run(1, 16'h5000, 16'h5100, 1'b0, 1'b0, 1'b0);

        // start held high across two back-to-back operations
        fill(14, 16'h6000);
        run(3, 16'h6000, 16'h6100, 1'b1, 1'b0, 1'b0);
        run(3, 16'h6000, 16'h6100, 1'b0, 1'b1, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++)
            check($sformatf("queue_drained_dut%0d", i), 64'(exp_q[i].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
